// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
//   mem_req   : read request, held until acknowledged or abandoned
//   mem_addr  : read address, stable while mem_req is high
//   mem_ack   : read-complete strobe from memory
//   mem_rdata : read data, valid with mem_ack
interface fetch_unit_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: owns the PC and IR, issues one instruction read per fetch request,
// waits up to TIMEOUT cycles for the memory ack, and flags a sticky error on timeout.
// Ports:
//   CLK, Reset            : clock, synchronous active-high reset
//   IRWrite, IorM         : fetch request pulse; only instruction accesses (IorM=0) fetch
//   PCWrite, Jcontrol     : PC update enable and source select
//   isZero, acc15         : branch qualifiers for Jcontrol 10 / 11
//   jumpTarget            : branch/jump destination (bit 0 ignored)
//   mem                   : instruction-memory read port
//   Opcode, Func, Imm     : decoded fields of IR
//   PC, busy, fetch_err   : program counter, fetch outstanding, sticky timeout flag
module fetch_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                IRWrite,
  input  logic                IorM,
  input  logic                PCWrite,
  input  logic [1:0]          Jcontrol,
  input  logic                isZero,
  input  logic                acc15,
  input  logic [15:0]         jumpTarget,
  fetch_unit_if.master        mem,
  output logic [3:0]          Opcode,
  output logic [2:0]          Func,
  output logic [11:0]         Imm,
  output logic [15:0]         PC,
  output logic                busy,
  output logic                fetch_err
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [15:0]      pc_q, pc_nxt;
  logic [15:0]      ir_q, ir_nxt;
  logic [15:0]      addr_q, addr_nxt;
  logic             req_q, req_nxt;
  logic             err_q, err_nxt;

  logic [15:0]      pc_inc;
  logic [15:0]      target;

  assign pc_inc = pc_q + 16'd2;
  assign target = jumpTarget & 16'hFFFE;

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      pc_q    <= pc_nxt;
      ir_q    <= ir_nxt;
      addr_q  <= addr_nxt;
      req_q   <= req_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next-state: PC update is independent of the fetch FSM
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    pc_nxt    = pc_q;
    ir_nxt    = ir_q;
    addr_nxt  = addr_q;
    req_nxt   = req_q;
    err_nxt   = err_q;

    if (PCWrite) begin
      unique case (Jcontrol)
        2'b00:   pc_nxt = pc_inc;
        2'b01:   pc_nxt = target;
        2'b10:   pc_nxt = isZero ? target : pc_inc;
        default: pc_nxt = acc15 ? target : pc_inc;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        // Address uses the current PC, so a same-cycle PCWrite does not affect it
        if (IRWrite && !IorM) begin
          addr_nxt  = pc_q;
          req_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.mem_ack) begin
          ir_nxt    = mem.mem_rdata;
          req_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign busy         = req_q;
  assign fetch_err    = err_q;
  assign PC           = pc_q;
  assign Opcode       = ir_q[15:12];
  assign Func         = ir_q[2:0];
  assign Imm          = ir_q[11:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int TMO = 15;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        IRWrite = 1'b0;
  logic        IorM = 1'b0;
  logic        PCWrite = 1'b0;
  logic [1:0]  Jcontrol = 2'b00;
  logic        isZero = 1'b0;
  logic        acc15 = 1'b0;
  logic [15:0] jumpTarget = 16'h0000;
  logic [3:0]  Opcode;
  logic [2:0]  Func;
  logic [11:0] Imm;
  logic [15:0] PC;
  logic        busy;
  logic        fetch_err;

  fetch_unit_if mem_bus();

  fetch_unit #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .Reset(Reset), .IRWrite(IRWrite), .IorM(IorM), .PCWrite(PCWrite),
    .Jcontrol(Jcontrol), .isZero(isZero), .acc15(acc15), .jumpTarget(jumpTarget),
    .mem(mem_bus), .Opcode(Opcode), .Func(Func), .Imm(Imm), .PC(PC),
    .busy(busy), .fetch_err(fetch_err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [15:0] m_pc, m_ir;
  logic        m_err;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // PC rule: taken branches go to the even-aligned target, otherwise PC+2 mod 64K
  function automatic logic [15:0] ref_next_pc(input logic [15:0] pc, input logic [1:0] jc,
                                              input logic jt_z, input logic jt_a,
                                              input logic [15:0] jt);
    bit taken;
    int v;
    taken = (jc == 2'd1) || (jc == 2'd2 && jt_z) || (jc == 2'd3 && jt_a);
    if (taken) v = int'(jt) - (int'(jt) % 2);
    else       v = (int'(pc) + 2) % 65536;
    return 16'(v);
  endfunction

  task automatic do_reset();
    Reset = 1'b1; IRWrite = 0; PCWrite = 0;
    mem_bus.mem_ack = 0; mem_bus.mem_rdata = 16'h0;
    tick(); tick();
    Reset = 1'b0;
    m_pc = 16'h0; m_ir = 16'h0; m_err = 1'b0;
  endtask

  task automatic check_state(input string tag);
    total++;
    if (PC !== m_pc) begin bad++; $display("FAIL %s pc got=%h exp=%h", tag, PC, m_pc); end
    total++;
    if ({Opcode, Func, Imm} !== {m_ir[15:12], m_ir[2:0], m_ir[11:0]}) begin
      bad++; $display("FAIL %s ir_fields got=%h/%h/%h exp_ir=%h", tag, Opcode, Func, Imm, m_ir);
    end
    total++;
    if (fetch_err !== m_err) begin bad++; $display("FAIL %s err got=%b exp=%b", tag, fetch_err, m_err); end
    total++;
    if (mem_bus.mem_req !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s idle got req=%b busy=%b exp 0/0", tag, mem_bus.mem_req, busy);
    end
  endtask

  task automatic pc_write(input logic [1:0] jc, input logic [15:0] jt, input logic z,
                          input logic a, input logic [15:0] exp_const, input string tag);
    PCWrite = 1; Jcontrol = jc; jumpTarget = jt; isZero = z; acc15 = a;
    tick();
    PCWrite = 0;
    m_pc = ref_next_pc(m_pc, jc, z, a, jt);
    total++;
    if (PC !== exp_const || PC !== m_pc) begin
      bad++; $display("FAIL %s got=%h exp=%h model=%h", tag, PC, exp_const, m_pc);
    end
  endtask

  // Launch a fetch; memory acks after d waiting edges (d >= TMO means never).
  // pcw: -1 = PCWrite (Jc=00) on the launch edge, k>=0 = during wait cycle k, else none.
  task automatic run_fetch(input int d, input logic [15:0] data, input int pcw,
                           input bit irw_in_wait, input string tag);
    logic [15:0] exp_addr;
    int hi, exp_hi;
    exp_addr = m_pc;
    exp_hi = (d < TMO) ? d + 1 : TMO;
    IRWrite = 1; IorM = 0;
    PCWrite = (pcw == -1); Jcontrol = 2'b00;
    if (pcw == -1) m_pc = ref_next_pc(m_pc, 2'b00, 0, 0, 16'h0);
    tick();
    IRWrite = 0; PCWrite = 0;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      if (mem_bus.mem_req !== 1'b1) break;
      hi++;
      total++;
      if (mem_bus.mem_addr !== exp_addr || busy !== 1'b1) begin
        bad++; $display("FAIL %s addr_hold k=%0d got=%h busy=%b exp=%h", tag, k, mem_bus.mem_addr, busy, exp_addr);
      end
      mem_bus.mem_ack = (k == d);
      mem_bus.mem_rdata = (k == d) ? data : 16'($urandom);
      IRWrite = irw_in_wait && (k == 0);
      PCWrite = (k == pcw);
      if (k == pcw) m_pc = ref_next_pc(m_pc, 2'b00, 0, 0, 16'h0);
      tick();
    end
    mem_bus.mem_ack = 0; IRWrite = 0; PCWrite = 0;
    if (d < TMO) m_ir = data; else m_err = 1'b1;
    total++;
    if (hi !== exp_hi) begin bad++; $display("FAIL %s req_cycles got=%0d exp=%0d", tag, hi, exp_hi); end
    check_state(tag);
    if (irw_in_wait) begin
      tick();
      total++;
      if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL %s queued_fetch got req=%b exp=0", tag, mem_bus.mem_req); end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (mem_bus.mem_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0000", mem_bus.mem_addr); end
    check_state("reset");
  endtask

  task automatic test_basic_fetch();
    run_fetch(2, 16'h3A05, -2, 1'b0, "basic");
    total++;
    if (Opcode !== 4'd3 || Func !== 3'd5 || Imm !== 12'hA05) begin
      bad++; $display("FAIL basic_fields got=%h/%h/%h exp=3/5/a05", Opcode, Func, Imm);
    end
  endtask

  task automatic test_pc_sweep();
    pc_write(2'b01, 16'h0010, 0, 0, 16'h0010, "pc_set");
    pc_write(2'b00, 16'h0101, 0, 0, 16'h0012, "jc00");
    pc_write(2'b01, 16'h0101, 0, 0, 16'h0100, "jc01");
    pc_write(2'b10, 16'h0101, 0, 0, 16'h0102, "jc10_nz");
    pc_write(2'b11, 16'h0101, 0, 1, 16'h0100, "jc11_neg");
    pc_write(2'b10, 16'h0201, 1, 0, 16'h0200, "jc10_z");
    pc_write(2'b11, 16'h0301, 0, 0, 16'h0202, "jc11_pos");
    pc_write(2'b01, 16'hFFFF, 0, 0, 16'hFFFE, "pc_top");
    pc_write(2'b00, 16'h1234, 0, 0, 16'h0000, "wrap");
  endtask

  task automatic test_ignored();
    logic [15:0] ir_before;
    ir_before = m_ir;
    IRWrite = 1; IorM = 1;
    tick();
    IRWrite = 0; IorM = 0;
    check_state("iorm_data");
    mem_bus.mem_ack = 1; mem_bus.mem_rdata = 16'hBEEF;
    tick();
    mem_bus.mem_ack = 0;
    total++;
    if ({Opcode, Imm} !== {ir_before[15:12], ir_before[11:0]}) begin
      bad++; $display("FAIL idle_ack got=%h%h exp=%h", Opcode, Imm, ir_before);
    end
  endtask

  task automatic test_pc_during_fetch();
    pc_write(2'b01, 16'h0040, 0, 0, 16'h0040, "pc_40");
    run_fetch(3, 16'h5C71, 1, 1'b1, "pcw_wait");
    total++;
    if (PC !== 16'h0042) begin bad++; $display("FAIL pcw_wait_pc got=%h exp=0042", PC); end
    run_fetch(1, 16'h9013, -1, 1'b0, "same_cycle");
  endtask

  task automatic test_timeout();
    logic [15:0] ir_before;
    ir_before = m_ir;
    run_fetch(100, 16'hDEAD, -2, 1'b0, "timeout");
    total++;
    if (fetch_err !== 1'b1 || {Opcode, Imm} !== ir_before) begin
      bad++; $display("FAIL timeout_state got err=%b ir=%h%h exp 1/%h", fetch_err, Opcode, Imm, ir_before);
    end
    run_fetch(0, 16'h7A1C, -2, 1'b0, "after_timeout");
    total++;
    if (fetch_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", fetch_err); end
    do_reset();
    check_state("err_cleared");
  endtask

  task automatic test_reset_mid_wait();
    pc_write(2'b01, 16'h0088, 0, 0, 16'h0088, "pc_88");
    run_fetch(0, 16'h4321, -2, 1'b0, "pre_reset");
    IRWrite = 1; IorM = 0;
    tick();
    IRWrite = 0;
    tick();
    Reset = 1; mem_bus.mem_ack = 1; mem_bus.mem_rdata = 16'hBEEF;
    tick();
    Reset = 0; mem_bus.mem_ack = 0;
    m_pc = 16'h0; m_ir = 16'h0; m_err = 1'b0;
    check_state("reset_mid_wait");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic [1:0] jc;
        logic [15:0] jt, exp;
        logic z, a;
        jc = 2'($urandom_range(0, 3)); jt = 16'($urandom);
        z = 1'($urandom_range(0, 1)); a = 1'($urandom_range(0, 1));
        exp = ref_next_pc(m_pc, jc, z, a, jt);
        pc_write(jc, jt, z, a, exp, "rnd_pc");
      end else begin
        run_fetch(int'($urandom_range(0, 18)), 16'($urandom), int'($urandom_range(0, 6)) - 2,
                  1'($urandom_range(0, 1)), "rnd_fetch");
      end
    end
  endtask

  initial begin
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 16'h0;
    test_reset();
    test_basic_fetch();
    test_pc_sweep();
    test_ignored();
    test_pc_during_fetch();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 15, the maximum number of wait cycles for mem_ack before a fetch aborts.
REQ-002 SHALL provide CLK  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide Reset  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 SHALL provide IRWrite  input  1  fetch request pulse from the control unit.
REQ-005 SHALL provide IorM  input  1  0 = instruction access, 1 = data access.
REQ-006 SHALL provide PCWrite  input  1  PC update enable.
REQ-007 SHALL provide Jcontrol  input  2  PC source select.
REQ-008 SHALL provide isZero  input  1  zero flag; qualifies the conditional branch.
REQ-009 SHALL provide acc15  input  1  accumulator sign bit; qualifies the conditional branch.
REQ-010 SHALL provide jumpTarget  input  16  branch/jump destination address.
REQ-011 SHALL provide mem_ack  input  1  memory read-complete strobe.
REQ-012 SHALL provide mem_rdata  input  16  memory read data, valid when mem_ack=1.
REQ-013 SHALL provide mem_req  output  1  instruction read request.
REQ-014 SHALL provide mem_addr  output  16  instruction read address.
REQ-015 SHALL provide Opcode  output  4  IR[15:12], to the control unit.
REQ-016 SHALL provide Func  output  3  IR[2:0], to the control unit.
REQ-017 SHALL provide Imm  output  12  IR[11:0].
REQ-018 SHALL provide PC  output  16  current program counter.
REQ-019 SHALL provide busy  output  1  high while a fetch is outstanding.
REQ-020 SHALL provide fetch_err  output  1  sticky timeout flag.

Function
REQ-021 SHALL implement FSM states IDLE and WAIT.
REQ-022 IDLE: IRWrite=1 and IorM=0 sampled at edge N SHALL latch mem_addr<=PC, assert mem_req and busy from edge N, clear the wait counter, and go to WAIT.
REQ-023 IDLE: IRWrite=1 with IorM=1 SHALL be ignored.
REQ-024 WAIT: mem_req and mem_addr SHALL hold stable until mem_ack is sampled high.
REQ-025 WAIT: mem_ack=1 at edge M SHALL load IR<=mem_rdata, drop mem_req and busy, and return to IDLE; Opcode/Func/Imm reflect the new IR from edge M.
REQ-026 WAIT: IRWrite SHALL be ignored; no queueing.
REQ-027 WAIT: the 4-bit wait counter SHALL increment on each edge with mem_ack=0.
REQ-028 Timeout: mem_ack still 0 with counter=TIMEOUT-1 SHALL drop mem_req/busy, keep IR unchanged, set fetch_err, and return to IDLE.
REQ-029 mem_ack while IDLE SHALL be ignored.
REQ-030 fetch_err SHALL clear only on Reset.
REQ-031 PCWrite=1 SHALL update PC at the edge per Jcontrol: 00 -> PC+2; 01 -> jumpTarget; 10 -> isZero ? jumpTarget : PC+2; 11 -> acc15 ? jumpTarget : PC+2.
REQ-032 PC+2 SHALL be modulo 2^16; 0xFFFE wraps to 0x0000.
REQ-033 jumpTarget bit 0 SHALL be forced to 0.
REQ-034 PCWrite SHALL be honoured in any state; an update during WAIT SHALL NOT change the latched mem_addr.
REQ-035 IRWrite and PCWrite in the same IDLE cycle SHALL fetch from the pre-update PC.

Reset
REQ-036 Reset=1 at an edge SHALL set PC=0x0000, IR=0x0000 (Opcode=0, Func=0, Imm=0), mem_addr=0, mem_req=0, busy=0, fetch_err=0, wait counter=0, state=IDLE.
REQ-037 Reset SHALL take priority over every other input, including mid-fetch; a mem_ack in the reset cycle SHALL be discarded.

Verification
REQ-038 Reset; IRWrite=1, IorM=0 at PC=0; mem_ack with rdata=0x3A05 two cycles later -> mem_addr=0x0000, mem_req high 3 cycles, then Opcode=3, Func=5, Imm=0xA05, busy=0.
REQ-039 PCWrite sweep from PC=0x0010, jumpTarget=0x0101: Jc=00 -> 0x0012; 01 -> 0x0100; 10, isZero=0 -> 0x0102; 11, acc15=1 -> 0x0100.
REQ-040 PC=0xFFFE, PCWrite=1, Jc=00 -> PC=0x0000.
REQ-041 Fetch with mem_ack never asserted, TIMEOUT=15 -> mem_req drops after 15 wait cycles, fetch_err=1, IR unchanged; fetch_err stays 1 until Reset.
REQ-042 Fetch at PC=0x0040, PCWrite Jc=00 during WAIT, then mem_ack -> mem_addr stays 0x0040, PC=0x0042, and IR loads.
REQ-043 Reset mid-WAIT with mem_ack in the same cycle -> mem_req=0, IR=0, PC=0 at that edge.
